mul_unit: RTL and testbench

Iterative 32×32 multiply unit for the ARM-style datapath. It takes operands from the register file read ports (rd1, rd2, and a third accumulate operand) and computes the low 32 bits of the product with a shift-add algorithm, one multiplier bit per cycle. It returns the result, write address and write enable to the register file write port (wd3, wa3, we3) as a single-cycle writeback pulse. It also produces N/Z flags for MULS/MLAS.

---
 rtl/mul_unit_if.sv | 33 +++
 rtl/mul_unit.sv | 103 ++++++++++
 tb/tb_mul_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/mul_unit_if.sv
// mul_unit_if: request/response bundle between the issue logic and the
// iterative multiply unit. Master drives the request, slave is the unit.
interface mul_unit_if #(
  parameter int WIDTH = 32
);
  // request (register file read side, latched on start)
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] acc;
  logic             accumulate;
  logic [3:0]       wa_in;
  logic             setflags_in;
  // response (register file write side and flags)
  logic             busy;
  logic             done;
  logic             we;
  logic [3:0]       wa;
  logic [WIDTH-1:0] result;
  logic             flag_n;
  logic             flag_z;
  logic             flags_we;

  modport master (
    output start, a, b, acc, accumulate, wa_in, setflags_in,
    input  busy, done, we, wa, result, flag_n, flag_z, flags_we
  );

  modport slave (
    input  start, a, b, acc, accumulate, wa_in, setflags_in,
    output busy, done, we, wa, result, flag_n, flag_z, flags_we
  );
endinterface

// File: rtl/mul_unit.sv
// mul_unit: iterative shift-add multiplier, one multiplier bit per cycle.
// Produces low WIDTH bits of a*b (optionally +acc) as a one-cycle writeback
// pulse with N/Z flags. Optional feature macro: MLA_EN (accumulate support).
// The interface instance must use the same WIDTH as this module.
module mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  mul_unit_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mplr_q, acc_q, result_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       wa_q;
  logic             s_q, fn_q, fz_q;

  logic             accept_w, last_w;
  logic [WIDTH-1:0] add_w, init_w;

  assign accept_w = (state_q == IDLE) && bus.start;
  assign last_w   = (cnt_q == CW'(WIDTH - 1));
  assign add_w    = acc_q + (mplr_q[0] ? mcand_q : '0);

`ifdef MLA_EN
  assign init_w = bus.accumulate ? bus.acc : '0;
`else
  // acc/accumulate are intentionally ignored without MLA support
  logic unused_mla;
  assign unused_mla = ^{bus.acc, bus.accumulate};
  assign init_w     = '0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state and status outputs
  always_comb begin
    state_d  = state_q;
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN: begin
        bus.busy = 1'b1;
        if (last_w) state_d = DONE;
      end
      DONE: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // datapath: operand latch, shift-add iteration, registered result/flags
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplr_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      wa_q     <= '0;
      s_q      <= 1'b0;
      result_q <= '0;
      fn_q     <= 1'b0;
      fz_q     <= 1'b0;
    end else if (accept_w) begin
      mcand_q <= bus.a;
      mplr_q  <= bus.b;
      acc_q   <= init_w;
      cnt_q   <= '0;
      wa_q    <= bus.wa_in;
      s_q     <= bus.setflags_in;
    end else if (state_q == RUN) begin
      acc_q   <= add_w;
      mcand_q <= mcand_q << 1;
      mplr_q  <= mplr_q >> 1;
      cnt_q   <= cnt_q + CW'(1);
      // capture the final sum so result/flags are stable through DONE
      if (last_w) begin
        result_q <= add_w;
        fn_q     <= add_w[WIDTH-1];
        fz_q     <= (add_w == '0);
      end
    end
  end

  assign bus.we       = bus.done;
  assign bus.wa       = wa_q;
  assign bus.result   = result_q;
  assign bus.flag_n   = fn_q;
  assign bus.flag_z   = fz_q;
  assign bus.flags_we = bus.done & s_q;
endmodule

// File: tb/tb_mul_unit.sv
// tb_mul_unit: directed and random operations against a plain-arithmetic
// model of the multiply unit (expected = a*b [+acc] mod 2^32).
module tb_mul_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mul_unit_if #(.WIDTH(32)) bus ();
  mul_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] a, b, acc, input logic accum);
    logic [31:0] p;
    p = a * b;
`ifdef MLA_EN
    if (accum) p = p + acc;
`endif
    return p;
  endfunction

  // Issue one operation; optionally pulse a stray start at cycle inj or a
  // reset at cycle rst_at (0 = none); run for lim cycles after acceptance.
  task automatic do_op(input logic [31:0] a, b, acc, input logic accum,
                       input logic [3:0] wa, input logic s,
                       input int inj, input int rst_at, input int lim);
    logic [31:0] exp;
    int dones, lat;
    exp   = model(a, b, acc, accum);
    dones = 0;
    lat   = 0;
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.acc = acc;
    bus.accumulate = accum; bus.wa_in = wa; bus.setflags_in = s;
    for (int n = 1; n <= lim; n++) begin
      @(posedge clk); @(negedge clk);
      bus.start = 1'b0;
      bus.a = $urandom; bus.b = $urandom; bus.acc = $urandom;
      bus.wa_in = 4'($urandom); bus.accumulate = 1'($urandom);
      if (rst_at != 0 && n == rst_at + 1) begin
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_we", 32'(bus.we), 0);
        chk("rst_result", bus.result, 0);
        chk("rst_wa", 32'(bus.wa), 0);
        chk("rst_flags", {29'd0, bus.flag_n, bus.flag_z, bus.flags_we}, 0);
        reset = 1'b0;
      end
      if (n == 1)  chk("busy_first", 32'(bus.busy), 1);
      if (bus.done) begin
        dones++;
        if (dones == 1) begin
          lat = n;
          chk("result", bus.result, exp);
          chk("wa", 32'(bus.wa), 32'(wa));
          chk("we", 32'(bus.we), 1);
          chk("flag_n", 32'(bus.flag_n), 32'(exp[31]));
          chk("flag_z", 32'(bus.flag_z), 32'(exp == 0));
          chk("flags_we", 32'(bus.flags_we), 32'(s));
          chk("busy_done", 32'(bus.busy), 1);
        end
      end
      if (rst_at == 0 && n == 34) begin
        chk("idle_busy", 32'(bus.busy), 0);
        chk("idle_we", 32'(bus.we), 0);
        chk("hold_result", bus.result, exp);
      end
      if (inj != 0 && n == inj) begin
        bus.start = 1'b1; bus.setflags_in = 1'($urandom);
      end
      if (rst_at != 0 && n == rst_at) reset = 1'b1;
    end
    bus.start = 1'b0;
    if (rst_at != 0) chk("abort_dones", 32'(dones), 0);
    else begin
      chk("done_count", 32'(dones), 1);
      chk("latency", 32'(lat), 33);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.acc = '0;
    bus.accumulate = 1'b0; bus.wa_in = '0; bus.setflags_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_done", 32'(bus.done), 0);
    chk("reset_result", bus.result, 0);
    chk("reset_misc", {23'd0, bus.wa, bus.we, bus.flag_n, bus.flag_z, bus.flags_we}, 0);
    reset = 1'b0;
    @(negedge clk);

    do_op(32'd3, 32'd5, 32'd0, 1'b0, 4'd4, 1'b0, 0, 0, 40);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b0, 4'd2, 1'b1, 0, 0, 40);
    do_op(32'd7, 32'd6, 32'd100, 1'b1, 4'd3, 1'b0, 0, 0, 40);
    do_op(32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 4'd5, 1'b1, 0, 0, 40);
    do_op(32'h8000_0000, 32'd1, 32'd0, 1'b0, 4'd6, 1'b1, 0, 0, 40);
    do_op(32'h1234_5678, 32'd0, 32'd9, 1'b1, 4'd15, 1'b1, 0, 0, 40);
    // stray start mid-run, then reset mid-run
    do_op(32'd11, 32'd13, 32'd0, 1'b0, 4'd7, 1'b0, 10, 0, 60);
    do_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 32'd1, 1'b1, 4'd8, 1'b1, 0, 16, 60);
    // back-to-back random operations at the minimum issue interval
    for (int i = 0; i < 8; i++)
      do_op($urandom, $urandom, $urandom, 1'($urandom), 4'($urandom),
            1'($urandom), 0, 0, 34);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
